uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver for 8N1-style async serial, the receive-side consumer of the baud generator's 16x oversample strobe.
- Synchronises the rx pin, detects and validates the start bit, samples each bit at mid-bit and checks the stop bit.
- Delivers bytes to the fabric over a valid/ready handshake, with frame-error and overrun flags.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- rx_clk  input  1  one-clk-cycle enable strobe at 16x BAUD_RATE, from the baud generator. Not a clock.
- rx  input  1  asynchronous serial line; idles high.
- data  output  DATA_BITS  received word; stable while data_valid is high.
- data_valid  output  1  word available; held until accepted.
- data_ready  input  1  consumer accepts the word when data_valid && data_ready at a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a new word completed while data_valid was still high.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data = 0, data_valid = 0, frame_err = 0, overrun = 0, busy = 0, FSM = IDLE, both synchroniser flops = 1.
- rst takes priority over every event, including mid-frame; a partial frame is discarded.
- Synchroniser: rx passes through 2 flops. All decisions use the second flop (rx_s), which adds 2 clk of latency.
- FSM state updates occur only on clk edges where rx_clk = 1, except the data_valid/data_ready handshake, which is evaluated every clk.
- 4-bit tick counter tcnt; bit counter bcnt, $clog2(DATA_BITS) bits wide.
- IDLE: on a tick with rx_s = 0, go to START with tcnt = 0.
- START: tcnt increments per tick. When tcnt = 7, sample rx_s:
  - 0: go to DATA with tcnt = 0, bcnt = 0.
  - 1: false start (glitch); return to IDLE with no flags.
- DATA: when tcnt = 15, sample rx_s into shift register bit bcnt (LSB first) and clear tcnt. After bit DATA_BITS-1, go to PARITY (if compiled in), otherwise STOP.
- STOP: when tcnt = 15, sample rx_s:
  - 1: commit the word. data <= shift register, data_valid <= 1 on the clk edge after the sampling tick. Go to IDLE.
  - 0: frame_err pulses for 1 cycle; data and data_valid are unchanged. Go to BREAK.
- BREAK: wait for a tick with rx_s = 1, then go to IDLE. This prevents a held-low line (break) from producing repeated frames.
- Commit while data_valid = 1 and not accepted in the same cycle: overrun pulses, data is overwritten with the new word, data_valid stays 1.
- Commit in the same cycle as acceptance: no overrun; data_valid stays 1 with the new word.
- Acceptance with no commit: data_valid <= 0 on the next edge.
- tcnt wraps modulo 16 and is always cleared on state entry.
- A glitch shorter than 8 ticks at the start bit is rejected.
- Back-to-back frames: a start edge is accepted on the first tick after STOP returns to IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP; the parity bit is sampled at tcnt = 15.
  - A mismatch against the XOR of the data bits, combined with PARITY_ODD, makes parity_err pulse 1 cycle alongside the commit. The word is still delivered.
  - Adds output port parity_err, 1 bit, reset value 0.
- Undefined: no PARITY state and no parity_err port. STOP directly follows the last data bit.

Test Plan:
- rx_clk every clk; send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop high), data_ready = 1 -> data = 0xA5, data_valid high for exactly 1 cycle, frame_err = 0, overrun = 0, busy returns to 0.
- rx low for 4 ticks then high -> no data_valid, no flags, FSM back in IDLE, busy = 0 within 8 ticks.
- Send 0x3C with the stop bit driven low, then hold rx low for 40 ticks, then high -> one frame_err pulse, no data_valid, busy stays high until rx returns high, then the next frame 0x55 is received correctly.
- data_ready = 0; send 0x11 then 0x22 back-to-back -> after the second stop, overrun pulses once, data = 0x22, data_valid = 1; raise data_ready -> data_valid clears next cycle.
- Assert rst during bit 4 of 0xF0, release, send 0x0F -> only 0x0F delivered, all outputs 0 during reset.
- UART_RX_PARITY_EN, PARITY_ODD = 0: send 0x07 with parity bit 0 -> data = 0x07 and parity_err pulses; resend with parity bit 1 -> no parity_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver driven by a 16x oversample enable strobe.
// Two-flop rx synchroniser, start-bit validation at mid-bit, LSB-first data
// sampling, stop-bit check with break hold-off, valid/ready output handshake.
// Optional parity stage and parity_err port: define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_s1_q, rx_s_q;
  logic                 commit, ferr;
  logic [DATA_BITS-1:0] data_q;
  logic                 data_valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q;
`endif

  // Two-flop synchroniser on the asynchronous rx line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s_q  <= rx_s1_q;
    end
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
    shift_q <= shift_d;
  end

  // Next-state logic; everything advances only on oversample ticks.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    commit  = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (rx_clk) begin
      tcnt_d = tcnt_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) state_d = S_START;
        end
        S_START: begin
          // Mid start bit: a line back high means it was only a glitch.
          if (tcnt_q == 4'd7) begin
            state_d = rx_s_q ? S_IDLE : S_DATA;
            bcnt_d  = '0;
          end
        end
        S_DATA: begin
          if (tcnt_q == 4'd15) begin
            shift_d[bcnt_q] = rx_s_q;
            if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tcnt_q == 4'd15) begin
            par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tcnt_q == 4'd15) begin
            if (rx_s_q) begin
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Hold off until the line returns high so a break is one error.
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) tcnt_d = '0;
    end
  end

  // Output word, handshake and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= ferr;
      overrun_q   <= commit && data_valid_q && !data_ready;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= commit && par_bad_q;
`endif
      if (commit) begin
        data_q       <= shift_q;
        data_valid_q <= 1'b1;
      end else if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif
  assign busy       = (state_q != S_IDLE);

endmodule
